// File: rtl/multi_prio_scan_if.sv
// Handshake bundle for multi_prio_scan: scan request side plus the
// valid/ready index stream and completion status.
interface multi_prio_scan_if #(
  parameter int N = 12,
  parameter int K = 2
);
  localparam int W = $clog2(N + 1);
  localparam int C = $clog2(K + 1);

  logic         start;
  logic         dir;
  logic [N:1]   r;
  logic         idle;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] idx;
  logic         last;
  logic         done_tick;
  logic [C-1:0] count;

  modport master (
    output start, dir, r, out_ready,
    input  idle, out_valid, idx, last, done_tick, count
  );

  modport slave (
    input  start, dir, r, out_ready,
    output idle, out_valid, idx, last, done_tick, count
  );
endinterface

// File: rtl/multi_prio_scan.sv
// Sequential multi-priority scanner: captures a request vector on start and
// streams up to K set-bit indices (1..N, 0 = none) highest- or lowest-first.
module multi_prio_scan #(
  parameter int N = 12,
  parameter int K = 2
) (
  input  logic              clk,
  input  logic              reset,
  multi_prio_scan_if.slave  bus
);
  localparam int W = $clog2(N + 1);
  localparam int C = $clog2(K + 1);

  typedef enum logic [1:0] {IDLE, SCAN, EMIT, DONE} state_t;

  state_t       state;
  logic [N:1]   mask;
  logic         dir_q;
  logic [C-1:0] cnt;
  logic [W-1:0] idx_q;
  logic         out_valid_q;
  logic         last_q;
  logic         done_q;

  logic [W-1:0] sel;
  logic [N:1]   sel_oh;
  logic [N:1]   mask_clr;
  logic         last_nxt;

  // The later match in each loop wins, so the loop order sets the priority.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    sel    = '0;
    sel_oh = '0;
    if (dir_q) begin
      for (int i = N; i >= 1; i--) begin
        if (mask[i]) begin
          sel       = W'(i);
          sel_oh    = '0;
          sel_oh[i] = 1'b1;
        end
      end
    end else begin
      for (int i = 1; i <= N; i++) begin
        if (mask[i]) begin
          sel       = W'(i);
          sel_oh    = '0;
          sel_oh[i] = 1'b1;
        end
      end
    end
  end

  assign mask_clr = mask & ~sel_oh;
  assign last_nxt = (cnt == C'(K - 1)) || (mask_clr == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      mask        <= '0;
      dir_q       <= 1'b0;
      cnt         <= '0;
      idx_q       <= '0;
      out_valid_q <= 1'b0;
      last_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every register update on the same edge.
      case (state)
        IDLE: begin
          if (bus.start) begin
            mask  <= bus.r;
            dir_q <= bus.dir;
            cnt   <= '0;
            state <= SCAN;
          end
        end
        SCAN: begin
          if (mask == '0 || cnt == C'(K)) begin
            done_q <= 1'b1;
            state  <= DONE;
          end else begin
            idx_q       <= sel;
            mask        <= mask_clr;
            out_valid_q <= 1'b1;
            last_q      <= last_nxt;
            state       <= EMIT;
          end
        end
        EMIT: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            idx_q       <= '0;
            last_q      <= 1'b0;
            cnt         <= cnt + C'(1);
            state       <= SCAN;
          end
        end
        DONE: begin
          done_q <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.idle      = (state == IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.idx       = idx_q;
  assign bus.last      = last_q;
  assign bus.done_tick = done_q;
  assign bus.count     = cnt;

  // A stalled index must stay put until the consumer takes it.
  a_hold_stable: assert property (@(posedge clk) disable iff (reset)
    (out_valid_q && !bus.out_ready) |=> (out_valid_q && $stable(idx_q)));

  a_cnt_bound: assert property (@(posedge clk) disable iff (reset)
    (cnt <= C'(K)));
endmodule
